pipe_datapath: RTL and testbench
================================

# pipe_datapath

Two-stage pipelined, width-parametrised execution datapath: register file, operand forwarding, eight-function ALU and a valid/ready result port with backpressure. It accepts decoded operations (register indices, immediate, control) from the control unit, executes them and commits results to the register file in order. It replaces the single-cycle add-only datapath in the core.

## Interface
Parameters:
- DATA_WIDTH, 32, register/ALU width (≥8, power of two)
- ADDRESS_WIDTH, 5, register index width; 2**ADDRESS_WIDTH registers (≥4, so index 10 exists)

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operation offered
- in_ready  output  1  datapath can accept an operation this cycle
- rs1, rs2, rd  input  ADDRESS_WIDTH  source/destination register indices
- RegWrite  input  1  commit result to rd
- ALUsrc  input  1  1: operand 2 = ImmOp; 0: operand 2 = register rs2
- ALUctrl  input  3  ALU function
- ImmOp  input  DATA_WIDTH  immediate
- res_valid  output  1  result register holds a valid result
- res_ready  input  1  consumer accepts result
- result  output  DATA_WIDTH  ALU result of oldest operation
- EQ  output  1  operand1 == operand2 for that operation
- a0  output  DATA_WIDTH  committed content of register 10

## Operation
- Issue handshake: op accepted when in_valid && in_ready; sources resolved and captured into EX register that edge.
- Stages: EX (operands held, ALU evaluates combinationally), WB (result, EQ, rd, RegWrite held; drives outputs).
- Commit: on res_valid && res_ready edge, if RegWrite && rd != 0, regfile[rd] <= result. Register 0 reads 0; writes ignored.
- Forwarding at issue, per source, priority: EX stage ALU output (if ex_valid, RegWrite, rd match, rd != 0) > WB stage result (same conditions) > regfile. Result: no stalls from data hazards.
- ALUctrl: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed less-than (result 1/0, zero-extended), 110 shift left logical, 111 shift right logical; shift amount = operand2[$clog2(DATA_WIDTH)-1:0]. Add/sub wrap modulo 2**DATA_WIDTH, no flags.
- EQ computed on ALU operands after ALUsrc mux, registered with result.
- Ops with RegWrite=0 still produce result/EQ and still require handshake.

## Timing
- Reset (async): ex_valid=0, res_valid=0, result=0, EQ=0, all registers 0, a0=0; in_ready=1 after reset deasserts.
- Flow control: wb_adv = !res_valid || res_ready; ex_adv = !ex_valid || wb_adv; in_ready = ex_adv (combinational, no dependency on in_valid).
- Latency: accepted at edge N -> res_valid high in cycle after edge N+1; regfile/a0 update at the commit edge, visible next cycle.
- Throughput: one op per cycle while res_ready=1.
- Backpressure: res_ready=0 with res_valid=1 holds WB; if EX also valid, in_ready=0 same cycle. Held operands are never re-read.
- Simultaneous commit and issue reading same register: forwarding from WB supplies value; no bubble.
- Reset mid-operation: in-flight ops discarded, uncommitted writes lost.

## Structure
- Package dp_pkg: alu_op_t enum (ALU_ADD..ALU_SRL, 3 bits), A0_IDX = 10, REG_ZERO = 0.
- Sub-module pipe_alu (DATA_WIDTH param): combinational, operands + alu_op_t -> result, eq. Register file and pipeline registers inline in pipe_datapath.

## Test plan
- Reset: assert rst mid-stream -> res_valid=0, a0=0, in_ready=1; reads of any register return 0.
- Back-to-back RAW: addi x1=5 (ALUsrc=1), then add x2=x1+x1, then add x10=x2+x1 consecutive cycles -> results 5, 10, 15; a0=15 one cycle after third commit.
- ALU sweep (DATA_WIDTH=32): 3 - 5 -> 0xFFFFFFFE; slt(-1,1) -> 1; sll(1,33) -> 2; srl(0x80000000,31) -> 1; EQ=1 for 7 vs 7.
- Backpressure: hold res_ready=0 for 3 cycles with two ops in flight -> in_ready=0, result stable, no regfile write; release -> ops commit in order, no loss or duplication.
- x0 handling: write 0x1234 to rd=0 with RegWrite=1 -> next read of x0 returns 0, no forwarding of 0x1234.
- RegWrite=0: sub x3,x3 with RegWrite=0 -> EQ=1, result 0, x3 unchanged.

Source files
------------

// File: rtl/dp_pkg.sv
// Shared types and constants for the pipelined execution datapath.
package dp_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  localparam int A0_IDX   = 10;
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/pipe_alu.sv
// Combinational eight-function ALU with operand equality flag.
module pipe_alu
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic signed [DATA_WIDTH-1:0] op_a,
  input  logic signed [DATA_WIDTH-1:0] op_b,
  input  alu_op_t                      op,
  output logic signed [DATA_WIDTH-1:0] res,
  output logic                         eq
);

  localparam int SH_W = $clog2(DATA_WIDTH);

  logic [SH_W-1:0] shamt;
  logic            lt;

  assign shamt = op_b[SH_W-1:0];
  // Both operands are declared signed, so this is a two's-complement compare.
  assign lt    = (op_a < op_b);
  assign eq    = (op_a == op_b);

  always_comb begin
    res = '0;
    unique case (op)
      ALU_ADD: res = op_a + op_b;
      ALU_SUB: res = op_a - op_b;
      ALU_AND: res = op_a & op_b;
      ALU_OR:  res = op_a | op_b;
      ALU_XOR: res = op_a ^ op_b;
      ALU_SLT: res = {{(DATA_WIDTH-1){1'b0}}, lt};
      ALU_SLL: res = op_a << shamt;
      ALU_SRL: res = op_a >> shamt;
    endcase
  end

endmodule

// File: rtl/pipe_datapath.sv
// Two-stage (EX, WB) execution datapath with register file, issue-time
// forwarding and a valid/ready result port that commits in order.
module pipe_datapath
  import dp_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd,
  input  logic                     RegWrite,
  input  logic                     ALUsrc,
  input  logic [2:0]               ALUctrl,
  input  logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH-1:0]    result,
  output logic                     EQ,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int                     NREG     = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] ZERO_SEL = ADDRESS_WIDTH'(REG_ZERO);
  localparam logic [ADDRESS_WIDTH-1:0] A0_SEL   = ADDRESS_WIDTH'(A0_IDX);

  logic [DATA_WIDTH-1:0] regfile [NREG];

  logic                         vld_p0;
  logic signed [DATA_WIDTH-1:0] opa_p0;
  logic signed [DATA_WIDTH-1:0] opb_p0;
  alu_op_t                      op_p0;
  logic [ADDRESS_WIDTH-1:0]     rd_p0;
  logic                         we_p0;

  logic                         vld_p1;
  logic signed [DATA_WIDTH-1:0] res_p1;
  logic                         eq_p1;
  logic [ADDRESS_WIDTH-1:0]     rd_p1;
  logic                         we_p1;

  logic signed [DATA_WIDTH-1:0] alu_res;
  logic                         alu_eq;
  logic signed [DATA_WIDTH-1:0] src1;
  logic signed [DATA_WIDTH-1:0] src2;
  logic signed [DATA_WIDTH-1:0] opb_next;
  logic                         ex_fwd_ok;
  logic                         wb_fwd_ok;
  logic                         wb_adv;
  logic                         ex_adv;
  logic                         accept;
  logic                         commit;

  assign wb_adv   = !vld_p1 || res_ready;
  assign ex_adv   = !vld_p0 || wb_adv;
  assign in_ready = ex_adv;
  assign accept   = in_valid && ex_adv;
  assign commit   = vld_p1 && res_ready;

  // Issue-time operand resolution: youngest producer wins, so no hazard stalls.
  assign ex_fwd_ok = vld_p0 && we_p0 && (rd_p0 != ZERO_SEL);
  assign wb_fwd_ok = vld_p1 && we_p1 && (rd_p1 != ZERO_SEL);

  always_comb begin
    if (ex_fwd_ok && (rd_p0 == rs1))      src1 = alu_res;
    else if (wb_fwd_ok && (rd_p1 == rs1)) src1 = res_p1;
    else                                  src1 = regfile[rs1];
  end

  always_comb begin
    if (ex_fwd_ok && (rd_p0 == rs2))      src2 = alu_res;
    else if (wb_fwd_ok && (rd_p1 == rs2)) src2 = res_p1;
    else                                  src2 = regfile[rs2];
  end

  assign opb_next = ALUsrc ? ImmOp : src2;

  // ---- issue -> EX boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      we_p0  <= 1'b0;
    end else if (ex_adv) begin
      vld_p0 <= in_valid;
      we_p0  <= in_valid && RegWrite;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      opa_p0 <= src1;
      opb_p0 <= opb_next;
      op_p0  <= alu_op_t'(ALUctrl);
      rd_p0  <= rd;
    end
  end

  pipe_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .op_a (opa_p0),
    .op_b (opb_p0),
    .op   (op_p0),
    .res  (alu_res),
    .eq   (alu_eq)
  );

  // ---- EX -> WB boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      we_p1  <= 1'b0;
      res_p1 <= '0;
      eq_p1  <= 1'b0;
    end else if (wb_adv) begin
      vld_p1 <= vld_p0;
      we_p1  <= vld_p0 && we_p0;
      if (vld_p0) begin
        res_p1 <= alu_res;
        eq_p1  <= alu_eq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wb_adv && vld_p0) rd_p1 <= rd_p0;
  end

  // ---- WB -> register file commit ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regfile[i] <= '0;
    end else if (commit && we_p1 && (rd_p1 != ZERO_SEL)) begin
      regfile[rd_p1] <= res_p1;
    end
  end

  assign res_valid = vld_p1;
  assign result    = res_p1;
  assign EQ        = eq_p1;
  assign a0        = regfile[A0_SEL];

endmodule

// File: tb/tb_pipe_datapath.sv
// Bench for pipe_datapath: directed and random operations checked against a
// sequential-execution reference model with an in-flight result queue.
module tb_pipe_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUsrc;
  logic [2:0]  ALUctrl;
  logic [31:0] ImmOp;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] result;
  logic        EQ;
  logic [31:0] a0;

  pipe_datapath #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite), .ALUsrc(ALUsrc),
    .ALUctrl(ALUctrl), .ImmOp(ImmOp), .res_valid(res_valid),
    .res_ready(res_ready), .result(result), .EQ(EQ), .a0(a0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        eq;
    logic [4:0]  rd;
    logic        we;
    int          stage;
  } op_t;

  op_t         q[$];
  logic [31:0] arch [32];
  logic [31:0] comm [32];
  int          n_vec = 0;
  int          n_miss = 0;
  logic [31:0] last_res;
  logic        last_eq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  task automatic model_clear();
    q.delete();
    for (int i = 0; i < 32; i++) begin
      arch[i] = '0;
      comm[i] = '0;
    end
  endtask

  // One clock cycle: drive at negedge, check before the edge, advance model at the edge.
  task automatic cyc(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] d, input logic we, input logic src,
                     input logic [2:0] f, input logic [31:0] imm, input logic rr);
    bit          exp_vld, exp_rdy, do_commit, do_accept;
    op_t         o;
    logic [31:0] a, b;
    @(negedge clk);
    in_valid = v; rs1 = r1; rs2 = r2; rd = d; RegWrite = we; ALUsrc = src;
    ALUctrl = f; ImmOp = imm; res_ready = rr;
    #1;
    exp_vld = (q.size() > 0) && (q[0].stage == 1);
    exp_rdy = !((q.size() == 2) && !rr);
    chk("res_valid", 32'(res_valid), 32'(exp_vld));
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (exp_vld) begin
      chk("result", result, q[0].res);
      chk("EQ", 32'(EQ), 32'(q[0].eq));
    end
    do_commit = exp_vld && rr;
    do_accept = v && exp_rdy;
    @(posedge clk);
    if (do_commit) begin
      o = q.pop_front();
      if (o.we && o.rd != 5'd0) comm[o.rd] = o.res;
      last_res = o.res;
      last_eq  = o.eq;
    end
    if (q.size() > 0 && q[0].stage == 0) q[0].stage = 1;
    if (do_accept) begin
      a = arch[r1];
      b = src ? imm : arch[r2];
      o.res = ref_alu(f, a, b);
      o.eq = (a == b);
      o.rd = d;
      o.we = we;
      o.stage = 0;
      q.push_back(o);
      if (we && d != 5'd0) arch[d] = o.res;
    end
    #1;
    chk("a0", a0, comm[10]);
  endtask

  task automatic op(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                    input logic we, input logic src, input logic [2:0] f, input logic [31:0] imm);
    cyc(1'b1, r1, r2, d, we, src, f, imm, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b1);
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
    #1;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_a0", a0, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_EQ", 32'(EQ), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic        v, we, src, rr;
    logic [4:0]  r1, r2, d;
    logic [2:0]  f;
    logic [31:0] imm;
    rst = 1'b1; in_valid = 1'b0; rs1 = '0; rs2 = '0; rd = '0; RegWrite = 1'b0;
    ALUsrc = 1'b0; ALUctrl = '0; ImmOp = '0; res_ready = 1'b1;
    last_res = '0; last_eq = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    do_reset();

    // Back-to-back read-after-write chain
    op(5'd0, 5'd0, 5'd1, 1'b1, 1'b1, 3'd0, 32'd5);
    op(5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 3'd0, 32'd0);
    op(5'd2, 5'd1, 5'd10, 1'b1, 1'b0, 3'd0, 32'd0);
    drain();
    chk("raw_last", last_res, 32'd15);
    chk("raw_a0", a0, 32'd15);

    // ALU sweep
    op(5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 3'd0, 32'd3);
    op(5'd3, 5'd0, 5'd4, 1'b1, 1'b1, 3'd1, 32'd5);
    drain();
    chk("sub_wrap", last_res, 32'hFFFF_FFFE);
    op(5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 3'd0, 32'hFFFF_FFFF);
    op(5'd5, 5'd0, 5'd6, 1'b1, 1'b1, 3'd5, 32'd1);
    drain();
    chk("slt_neg", last_res, 32'd1);
    op(5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 3'd0, 32'd1);
    op(5'd7, 5'd0, 5'd8, 1'b1, 1'b1, 3'd6, 32'd33);
    drain();
    chk("sll_mod", last_res, 32'd2);
    op(5'd0, 5'd0, 5'd9, 1'b1, 1'b1, 3'd0, 32'h8000_0000);
    op(5'd9, 5'd0, 5'd18, 1'b1, 1'b1, 3'd7, 32'd31);
    drain();
    chk("srl_31", last_res, 32'd1);
    op(5'd0, 5'd0, 5'd11, 1'b1, 1'b1, 3'd0, 32'd7);
    op(5'd11, 5'd0, 5'd12, 1'b1, 1'b1, 3'd1, 32'd7);
    drain();
    chk("eq_flag", 32'(last_eq), 32'd1);

    // Backpressure with two ops in flight
    cyc(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 1'b1, 3'd0, 32'h11, 1'b0);
    cyc(1'b1, 5'd10, 5'd0, 5'd14, 1'b1, 1'b1, 3'd0, 32'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b1, 3'd0, 32'h33, 1'b0);
      chk("bp_result", result, 32'h11);
      chk("bp_a0", a0, 32'd15);
    end
    cyc(1'b1, 5'd14, 5'd10, 5'd15, 1'b1, 1'b0, 3'd0, 32'h0, 1'b1);
    drain();
    chk("bp_order", last_res, 32'h44);
    chk("bp_commit_a0", a0, 32'h11);

    // Writes to x0 are dropped and never forwarded
    op(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 3'd0, 32'h1234);
    op(5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 3'd0, 32'd0);
    drain();
    chk("x0_read", last_res, 32'd0);

    // RegWrite=0 still produces result/EQ but leaves the register alone
    op(5'd3, 5'd3, 5'd3, 1'b0, 1'b0, 3'd1, 32'd0);
    drain();
    chk("nowr_res", last_res, 32'd0);
    chk("nowr_eq", 32'(last_eq), 32'd1);
    op(5'd3, 5'd0, 5'd17, 1'b1, 1'b0, 3'd0, 32'd0);
    drain();
    chk("nowr_x3", last_res, 32'd3);

    // Random traffic, with a reset dropped into the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
        op(5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 3'd0, 32'd0);
        op(5'd10, 5'd3, 5'd19, 1'b1, 1'b0, 3'd3, 32'd0);
        drain();
        chk("post_rst_read", last_res, 32'd0);
      end
      v   = ($urandom_range(0, 3) != 0);
      r1  = ($urandom_range(0, 4) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      r2  = ($urandom_range(0, 4) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      d   = ($urandom_range(0, 3) == 0) ? 5'd10 : 5'($urandom_range(0, 7));
      we  = ($urandom_range(0, 4) != 0);
      src = 1'($urandom_range(0, 1));
      f   = 3'($urandom_range(0, 7));
      imm = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      rr  = ($urandom_range(0, 3) != 0);
      cyc(v, r1, r2, d, we, src, f, imm, rr);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
